queue_enq_master: RTL and testbench
===================================

// Module: queue_enq_master
// PURPOSE
//  Write-side initiator for the slow valid/ack queue interface (queue accepts at most one word every second cycle).
//  Converts an upstream valid/ready stream into that valid/ack handshake: holds word + valid until ack, then presents next.
//  2-entry skid buffer keeps upstream ready across the mandatory ack cycle; watchdog flags a queue that never acks.
//  Sits between packet/descriptor producers and each queue instance.
// PARAMETERS
//  WIDTH     1    data word width (bits)
//  TIMEOUT   256  cycles of q_valid_o && q_ready_i without q_ack_i before proto_err_o sets; >=2
// PORTS
//  clk_i        in   1      single clock, all logic rising-edge
//  rst_ni       in   1      reset, asynchronous, active-low
//  s_data_i     in   WIDTH  upstream word
//  s_valid_i    in   1      upstream word valid
//  s_ready_o    out  1      upstream may transfer (transfer = s_valid_i && s_ready_o)
//  q_data_o     out  WIDTH  word presented to queue
//  q_valid_o    out  1      word presented to queue
//  q_ack_i      in   1      queue accepted q_data_o (arrives cycle after queue samples)
//  q_ready_i    in   1      queue not full and not in ack cycle (watchdog qualifier only)
//  clr_err_i    in   1      synchronous clear of proto_err_o
//  proto_err_o  out  1      sticky: timeout or spurious ack
// BEHAVIOUR
//  Reset (async, rst_ni=0): q_valid_o=0, s_ready_o=0 during reset, 1 first cycle after, proto_err_o=0, buffers empty,
//   watchdog=0. q_data_o value don't-care while q_valid_o=0. Reset mid-transfer discards both entries; no ack awaited.
//  Storage: CUR (drives q_data_o/q_valid_o), SPARE. All outputs registered; s_ready_o = !SPARE.valid (registered).
//  States (CUR view): EMPTY (q_valid_o=0), PRESENT (q_valid_o=1, waiting ack).
//   EMPTY:   transfer -> CUR<=s_data_i, PRESENT next cycle (latency 1 cycle s_valid_i -> q_valid_o).
//   PRESENT, no ack: q_data_o/q_valid_o held stable; transfer -> SPARE (s_ready_o drops next cycle).
//   PRESENT, ack:    SPARE.valid -> CUR<=SPARE, stay PRESENT; SPARE takes simultaneous transfer if any.
//                    else transfer this cycle -> CUR<=s_data_i, stay PRESENT; else -> EMPTY.
//  Queue ignores valid in its ack cycle; new word appears the cycle after ack -> sustained 1 word / 2 cycles.
//  Order strictly preserved; no word dropped or duplicated.
//  Watchdog: counts consecutive cycles q_valid_o && q_ready_i && !q_ack_i; cleared on ack or !q_valid_o;
//   holds (not cleared) while !q_ready_i (queue full is legal backpressure). Count==TIMEOUT-1 and
//   condition true -> proto_err_o<=1; counter saturates. Counter width $clog2(TIMEOUT+1).
//  Spurious ack (q_ack_i && !q_valid_o): ignored for data, proto_err_o<=1.
//  clr_err_i clears proto_err_o; same-cycle new error wins (stays 1).
// CONFIGURATION
//  QUEUE_ENQ_STATS_EN defined: extra ports push_cnt_o out 32 (words acked) and stall_cnt_o out 32
//   (cycles q_valid_o && !q_ack_i); both reset 0, wrap modulo 2^32, cleared by clr_err_i.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Package mfqs_queue_pkg: state encoding localparams (ST_EMPTY, ST_PRESENT), STATS_W=32, watchdog width function.
//  Sub-module queue_enq_skid: 2-entry CUR/SPARE buffer with load/advance controls; FSM + watchdog stay in top.
// TESTING
//  Back-to-back: 8 words 0x01..0x08, s_valid_i=1, model queue acking 1 cycle after sample -> 8 words in order,
//   q_valid_o word changes only cycle after ack, 16 cycles total +1 latency.
//  Upstream stall: ack arrives while SPARE full and s_valid_i=1 -> SPARE->CUR, new word->SPARE, none lost.
//  Queue full: q_ready_i=0 for 1000 cycles, TIMEOUT=256 -> proto_err_o stays 0, q_data_o stable.
//  Dead queue: q_ready_i=1, never ack -> proto_err_o=1 exactly TIMEOUT cycles after q_valid_o rose; clr_err_i clears.
//  Spurious ack with q_valid_o=0 -> proto_err_o=1, no word emitted.
//  Async reset asserted mid-PRESENT with SPARE full -> q_valid_o=0 immediately, both entries dropped, STATS counters 0.

Source files
------------

// File: rtl/queue_enq_master_pkg.sv
// Shared types and constants for the valid/ack queue write-side initiator.
package mfqs_queue_pkg;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } enq_state_e;

  localparam int unsigned STATS_W = 32;

  // Watchdog counter must be able to reach TIMEOUT itself so it can saturate there.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/queue_enq_master_if.sv
// Upstream valid/ready stream plus downstream valid/ack queue handshake.
interface queue_enq_master_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] s_data_i;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [WIDTH-1:0] q_data_o;
  logic             q_valid_o;
  logic             q_ack_i;
  logic             q_ready_i;

  modport master (
    input  s_data_i, s_valid_i, q_ack_i, q_ready_i,
    output s_ready_o, q_data_o, q_valid_o
  );

  modport slave (
    output s_data_i, s_valid_i, q_ack_i, q_ready_i,
    input  s_ready_o, q_data_o, q_valid_o
  );

endinterface

// File: rtl/queue_enq_skid.sv
// Two-entry CUR/SPARE word store; CUR validity is tracked by the owner's FSM.
module queue_enq_skid #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             cur_load_i,
  input  logic             advance_i,
  input  logic             spare_load_i,
  output logic [WIDTH-1:0] cur_data_o,
  output logic             spare_valid_o,
  output logic             spare_valid_nxt_o
);

  logic [WIDTH-1:0] cur_data_q, cur_data_d;
  logic [WIDTH-1:0] spare_data_q, spare_data_d;
  logic             spare_valid_q, spare_valid_d;

  always_comb begin
    cur_data_d    = cur_data_q;
    spare_data_d  = spare_data_q;
    spare_valid_d = spare_valid_q;
    if (advance_i) begin
      cur_data_d = spare_data_q;
    end else if (cur_load_i) begin
      cur_data_d = data_i;
    end
    // SPARE may be released and refilled by the same advance cycle.
    if (spare_load_i) begin
      spare_data_d  = data_i;
      spare_valid_d = 1'b1;
    end else if (advance_i) begin
      spare_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_data_q    <= '0;
      spare_data_q  <= '0;
      spare_valid_q <= 1'b0;
    end else begin
      cur_data_q    <= cur_data_d;
      spare_data_q  <= spare_data_d;
      spare_valid_q <= spare_valid_d;
    end
  end

  assign cur_data_o        = cur_data_q;
  assign spare_valid_o     = spare_valid_q;
  assign spare_valid_nxt_o = spare_valid_d;

endmodule

// File: rtl/queue_enq_master.sv
// Valid/ready to valid/ack bridge for a slow queue with skid buffer and ack watchdog.
// Optional QUEUE_ENQ_STATS_EN adds push/stall counters.
module queue_enq_master
  import mfqs_queue_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  queue_enq_master_if.master    bus,
  input  logic                  clr_err_i,
  output logic                  proto_err_o
`ifdef QUEUE_ENQ_STATS_EN
  ,
  output logic [STATS_W-1:0]    push_cnt_o,
  output logic [STATS_W-1:0]    stall_cnt_o
`endif
);

  localparam int unsigned     WD_W    = wdog_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

  enq_state_e      state_q, state_d;
  logic            s_ready_q, s_ready_d;
  logic            err_q, err_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  logic             xfer;
  logic             q_valid;
  logic             cur_load, advance, spare_load;
  logic             spare_valid, spare_valid_nxt;
  logic [WIDTH-1:0] cur_data;
  logic             wd_hit, spurious;

  assign xfer    = bus.s_valid_i && s_ready_q;
  assign q_valid = (state_q == ST_PRESENT);

  queue_enq_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .data_i            (bus.s_data_i),
    .cur_load_i        (cur_load),
    .advance_i         (advance),
    .spare_load_i      (spare_load),
    .cur_data_o        (cur_data),
    .spare_valid_o     (spare_valid),
    .spare_valid_nxt_o (spare_valid_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cur_load   = 1'b0;
    advance    = 1'b0;
    spare_load = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (xfer) begin
          cur_load = 1'b1;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (!bus.q_ack_i) begin
          spare_load = xfer;
        end else if (spare_valid) begin
          advance    = 1'b1;
          spare_load = xfer;
        end else if (xfer) begin
          cur_load = 1'b1;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    s_ready_d = !spare_valid_nxt;
  end

  // Queue-full backpressure freezes the count instead of clearing it.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_hit   = 1'b0;
    if (!q_valid || bus.q_ack_i) begin
      wd_cnt_d = '0;
    end else if (bus.q_ready_i) begin
      wd_hit = (wd_cnt_q == WD_LAST);
      if (wd_cnt_q != WD_MAX) begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end
    spurious = bus.q_ack_i && !q_valid;
    err_d    = err_q;
    if (clr_err_i) begin
      err_d = 1'b0;
    end
    if (wd_hit || spurious) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_EMPTY;
      s_ready_q <= 1'b0;
      err_q     <= 1'b0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      err_q     <= err_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign bus.q_valid_o = q_valid;
  assign bus.q_data_o  = cur_data;
  assign bus.s_ready_o = s_ready_q;
  assign proto_err_o   = err_q;

`ifdef QUEUE_ENQ_STATS_EN
  logic [STATS_W-1:0] push_cnt_q, push_cnt_d;
  logic [STATS_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    push_cnt_d  = push_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clr_err_i) begin
      push_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (q_valid && bus.q_ack_i) begin
        push_cnt_d = push_cnt_q + STATS_W'(1);
      end
      if (q_valid && !bus.q_ack_i) begin
        stall_cnt_d = stall_cnt_q + STATS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      push_cnt_q  <= push_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign push_cnt_o  = push_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_queue_enq_master.sv
// Scoreboard bench: upstream driver feeds words, a queue model samples/acks and checks order and hold.
`timescale 1ns/1ps
module tb_queue_enq_master;

  localparam int unsigned W  = 8;
  localparam int unsigned TO = 256;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_err;
  logic proto_err;
  logic model_ack;
  logic spur_ack;

  queue_enq_master_if #(.WIDTH(W)) qif ();

`ifdef QUEUE_ENQ_STATS_EN
  logic [31:0] push_cnt;
  logic [31:0] stall_cnt;
`endif

  queue_enq_master #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (qif),
    .clr_err_i   (clr_err),
    .proto_err_o (proto_err)
`ifdef QUEUE_ENQ_STATS_EN
    ,
    .push_cnt_o  (push_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign qif.q_ack_i = model_ack | spur_ack;

  int          checks = 0;
  int          fails  = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] send_q[$];
  logic [W-1:0] exp_q[$];
  int           valid_pct  = 100;
  bit           ack_en     = 1'b1;
  bit           ready_en   = 1'b1;
  bit           rand_ready = 1'b0;
  int           n_samples  = 0;
  int unsigned  last_sample_cyc = 0;
  int           model_push = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Upstream producer: offers the head of send_q, records accepted words as expected output.
  initial begin
    qif.s_valid_i = 1'b0;
    qif.s_data_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && send_q.size() > 0 && $urandom_range(99) < valid_pct) begin
        qif.s_valid_i = 1'b1;
        qif.s_data_i  = send_q[0];
      end else begin
        qif.s_valid_i = 1'b0;
        qif.s_data_i  = W'($urandom);
      end
      if (qif.s_valid_i && qif.s_ready_o) exp_q.push_back(send_q.pop_front());
    end
  end

  // Queue model + monitor: samples when valid and ready outside its ack cycle, acks next cycle.
  bit           ack_pending;
  bit           prev_valid;
  bit           prev_ack;
  logic [W-1:0] prev_data;
  logic [W-1:0] exp_word;
  initial begin
    ack_pending   = 1'b0;
    prev_valid    = 1'b0;
    prev_ack      = 1'b0;
    prev_data     = '0;
    model_ack     = 1'b0;
    qif.q_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_pending   = 1'b0;
        prev_valid    = 1'b0;
        model_ack     = 1'b0;
        model_push    = 0;
        qif.q_ready_i = 1'b0;
      end else begin
        if (clr_err) model_push = 0;
        if (prev_valid && !prev_ack) begin
          check("hold_valid", qif.q_valid_o, 1'b1);
          check("hold_data", qif.q_data_o, prev_data);
        end
        model_ack     = ack_pending;
        qif.q_ready_i = ready_en && !ack_pending && (!rand_ready || $urandom_range(99) < 75);
        ack_pending   = 1'b0;
        if (model_ack && qif.q_valid_o) model_push++;
        if (qif.q_valid_o && qif.q_ready_i && ack_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_word: got 0x%0h required no word (t=%0t)", qif.q_data_o, $time);
          end else begin
            exp_word = exp_q.pop_front();
            check("data_order", qif.q_data_o, exp_word);
          end
          n_samples++;
          last_sample_cyc = cyc;
          ack_pending     = 1'b1;
        end
        prev_valid = qif.q_valid_o;
        prev_data  = qif.q_data_o;
        prev_ack   = model_ack | spur_ack;
      end
    end
  end

  task automatic drain(input string name, input int max_cyc);
    int k;
    k = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0 || qif.q_valid_o) && k < max_cyc) begin
      tick();
      k++;
    end
    checks++;
    if (k >= max_cyc) begin
      fails++;
      $display("FAIL %s_drain: %0d words outstanding, required 0 within %0d cycles",
               name, send_q.size() + exp_q.size(), max_cyc);
    end
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  int          base;
  int unsigned t0;
  int          k;
  initial begin
    rst_n    = 1'b0;
    clr_err  = 1'b0;
    spur_ack = 1'b0;
    repeat (3) tick();
    check("reset_q_valid", qif.q_valid_o, 1'b0);
    check("reset_s_ready", qif.s_ready_o, 1'b0);
    check("reset_proto_err", proto_err, 1'b0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", qif.s_ready_o, 1'b1);
    check("idle_q_valid", qif.q_valid_o, 1'b0);
`ifdef QUEUE_ENQ_STATS_EN
    check("reset_push_cnt", push_cnt, 32'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
`endif

    // Back-to-back: word k is sampled 2k-1 cycles after the first offer.
    base = n_samples;
    t0   = cyc + 1;
    for (int i = 1; i <= 8; i++) send_q.push_back(W'(i));
    drain("b2b", 60);
    check("b2b_count", n_samples - base, 8);
    check("b2b_last_sample_cycle", last_sample_cyc - t0, 15);

    // Randomized traffic with random queue readiness.
    rand_ready = 1'b1;
    valid_pct  = 60;
    base       = n_samples;
    for (int i = 0; i < 150; i++) send_q.push_back(W'($urandom));
    drain("random", 3000);
    check("random_count", n_samples - base, 150);
    check("random_no_err", proto_err, 1'b0);
`ifdef QUEUE_ENQ_STATS_EN
    check("push_cnt", push_cnt, model_push);
`endif
    rand_ready = 1'b0;
    valid_pct  = 100;

    // Queue full for a long time is legal backpressure.
    ready_en = 1'b0;
    send_q.push_back(8'h5A);
    k = 0;
    while (!qif.q_valid_o && k < 20) begin tick(); k++; end
    for (int i = 0; i < 1000; i++) begin
      tick();
      check("full_no_err", proto_err, 1'b0);
    end
    check("full_valid_held", qif.q_valid_o, 1'b1);
    check("full_data_held", qif.q_data_o, 8'h5A);
    ready_en = 1'b1;
    drain("full", 40);

    // Dead queue: error exactly TIMEOUT cycles after q_valid rose.
    ack_en = 1'b0;
    send_q.push_back(8'hC3);
    k = 0;
    while (!qif.q_valid_o && k < 20) begin tick(); k++; end
    check("dead_valid_rose", qif.q_valid_o, 1'b1);
    for (int i = 1; i <= int'(TO); i++) begin
      tick();
      if (i == int'(TO) - 1) check("dead_err_early", proto_err, 1'b0);
      if (i == int'(TO))     check("dead_err_on_time", proto_err, 1'b1);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("dead_err_cleared", proto_err, 1'b0);
    repeat (5) tick();
    check("dead_err_stays_clear", proto_err, 1'b0);
    ack_en = 1'b1;
    drain("dead", 40);

    // Spurious ack while idle, then same-cycle error vs clear.
    base     = n_samples;
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    check("spur_err", proto_err, 1'b1);
    check("spur_no_valid", qif.q_valid_o, 1'b0);
    repeat (4) tick();
    check("spur_no_word", n_samples - base, 0);
    spur_ack = 1'b1;
    clr_err  = 1'b1;
    tick();
    spur_ack = 1'b0;
    clr_err  = 1'b0;
    check("err_wins_over_clr", proto_err, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_after_spur", proto_err, 1'b0);

    // Async reset with CUR and SPARE both occupied.
    ack_en = 1'b0;
    send_q.push_back(8'h11);
    send_q.push_back(8'h22);
    k = 0;
    while (!(qif.q_valid_o && !qif.s_ready_o) && k < 20) begin tick(); k++; end
    check("pre_reset_spare_full", qif.s_ready_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_q_valid", qif.q_valid_o, 1'b0);
    check("async_reset_s_ready", qif.s_ready_o, 1'b0);
`ifdef QUEUE_ENQ_STATS_EN
    check("async_reset_push_cnt", push_cnt, 32'd0);
    check("async_reset_stall_cnt", stall_cnt, 32'd0);
`endif
    send_q.delete();
    exp_q.delete();
    ack_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_mid_reset", qif.s_ready_o, 1'b1);
    check("no_stale_word", qif.q_valid_o, 1'b0);
    base = n_samples;
    send_q.push_back(8'hA1);
    send_q.push_back(8'hA2);
    drain("post_reset", 40);
    check("post_reset_count", n_samples - base, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
